// File: rtl/phase_sequencer.sv
// phase_sequencer: start-triggered generator of PHASES mutually exclusive,
// one-hot phase strobes. Each phase is held for a programmable number of
// cycles. A one-cycle Done pulse follows a normally completed train. Abort
// cancels silently, and Repeat makes the train free-run back to phase 0.
//
// The outputs are registered. Each edge loads them with a decode of the
// state that the same edge enters, so Phase_Out, Busy and Done switch
// together with the state and never glitch.
module phase_sequencer #(
    parameter int PHASES = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Start,
    input  logic                      Abort,
    input  logic                      Repeat,
    input  logic [PHASES*CNT_W-1:0]   Duration,
    output logic [PHASES-1:0]         Phase_Out,
    output logic                      Busy,
    output logic                      Done
);

    localparam int IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   phase_idx;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   cnt_next;
    logic               load;
    logic [CNT_W-1:0]   raw_field;
    logic               last_cycle;
    logic               last_phase;

    logic [PHASES-1:0]  phase_out_next;
    logic               busy_next;
    logic               done_next;

    // The counter counts down to 1. Fields are never loaded as 0, so the
    // "<= 1" test only guards against an unreachable zero count.
    assign last_cycle = (count <= CNT_ONE);
    assign last_phase = (phase_idx == LAST_IDX);

    // Select the duration field of the phase being entered on this edge.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        raw_field = '0;
        for (int k = 0; k < PHASES; k++) begin
            if (idx_next == IDX_W'(k)) begin
                raw_field = Duration[k*CNT_W +: CNT_W];
            end
        end
    end

    // State register: FSM state, phase index, counter and registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples its pre-edge value regardless of statement order.
            state     <= S_IDLE;
            phase_idx <= '0;
            count     <= '0;
            Phase_Out <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_next;
            phase_idx <= idx_next;
            count     <= cnt_next;
            Phase_Out <= phase_out_next;
            Busy      <= busy_next;
            Done      <= done_next;
        end
    end

    // Next-state logic. Abort outranks every other request, and Start is
    // only heard in IDLE.
    always_comb begin
        state_next = state;
        idx_next   = phase_idx;
        cnt_next   = count;
        load       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (Start && !Abort) begin
                    state_next = S_RUN;
                    idx_next   = '0;
                    load       = 1'b1;
                end
            end

            S_RUN: begin
                if (Abort) begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end else if (last_cycle) begin
                    if (!last_phase) begin
                        idx_next = phase_idx + IDX_W'(1);
                        load     = 1'b1;
                    end else if (Repeat) begin
                        idx_next = '0;
                        load     = 1'b1;
                    end else begin
                        state_next = S_DONE;
                        idx_next   = '0;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = count - CNT_ONE;
                end
            end

            S_DONE: begin
                // Done always lasts one cycle. Abort here also ends in IDLE,
                // so it needs no separate branch.
                state_next = S_IDLE;
                idx_next   = '0;
                cnt_next   = '0;
            end

            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
                cnt_next   = '0;
            end
        endcase

        // A zero field means one cycle, which keeps the counter from wrapping.
        if (load) begin
            cnt_next = (raw_field == '0) ? CNT_ONE : raw_field;
        end
    end

    // Output decode of the state being entered, registered by the state
    // register above.
    always_comb begin
        phase_out_next = '0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        if (state_next == S_RUN) begin
            phase_out_next = PHASES'(1) << idx_next;
            busy_next      = 1'b1;
        end
        if (state_next == S_DONE) begin
            done_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Each step drives the inputs for one
// cycle and pushes the outputs expected after the next rising edge onto a
// scoreboard queue. The outputs are sampled 1 time unit after that edge and
// compared with the popped entry. Two instances run: the default PHASES=2
// instance and a PHASES=3 instance.
module tb_phase_sequencer;

    typedef struct packed {
        logic [2:0] po;
        logic       busy;
        logic       done;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset_n;

    logic        start2, abort2, repeat2;
    logic [15:0] dur2;
    logic [1:0]  phase2;
    logic        busy2, done2;

    logic        start3, abort3, repeat3;
    logic [23:0] dur3;
    logic [2:0]  phase3;
    logic        busy3, done3;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    phase_sequencer #(.PHASES(2), .CNT_W(8)) u_dut2 (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (start2),
        .Abort     (abort2),
        .Repeat    (repeat2),
        .Duration  (dur2),
        .Phase_Out (phase2),
        .Busy      (busy2),
        .Done      (done2)
    );

    phase_sequencer #(.PHASES(3), .CNT_W(8)) u_dut3 (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (start3),
        .Abort     (abort3),
        .Repeat    (repeat3),
        .Duration  (dur3),
        .Phase_Out (phase3),
        .Busy      (busy3),
        .Done      (done3)
    );

    always #5 Clock = ~Clock;

    task automatic push_exp(input logic [2:0] po, input logic b, input logic d);
        exp_t e;
        e.po   = po;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag, input logic [2:0] po,
                             input logic b, input logic d);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (po === e.po) else begin
                errors++;
                $error("FAIL %s phase_out: got %b expected %b", tag, po, e.po);
            end
            checks++;
            assert (b === e.busy) else begin
                errors++;
                $error("FAIL %s busy: got %b expected %b", tag, b, e.busy);
            end
            checks++;
            assert (d === e.done) else begin
                errors++;
                $error("FAIL %s done: got %b expected %b", tag, d, e.done);
            end
        end
    endtask

    // One cycle on the PHASES=2 instance: drive, expect, edge, compare.
    task automatic step(input string tag, input logic st, input logic ab,
                        input logic rp, input logic [1:0] po,
                        input logic b, input logic d);
        start2  = st;
        abort2  = ab;
        repeat2 = rp;
        push_exp({1'b0, po}, b, d);
        @(posedge Clock);
        #1;
        check_out(tag, {1'b0, phase2}, busy2, done2);
    endtask

    // One cycle on the PHASES=3 instance.
    task automatic step3(input string tag, input logic st,
                         input logic [2:0] po, input logic b, input logic d);
        start3 = st;
        push_exp(po, b, d);
        @(posedge Clock);
        #1;
        check_out(tag, phase3, busy3, done3);
    endtask

    initial begin
        Reset_n = 1'b0;
        start2 = 0; abort2 = 0; repeat2 = 0; dur2 = 16'h0101;
        start3 = 0; abort3 = 0; repeat3 = 0; dur3 = 24'h0;

        // Reset state, held across edges.
        repeat (2) @(posedge Clock);
        #1;
        push_exp(3'b000, 1'b0, 1'b0);
        check_out("reset2", {1'b0, phase2}, busy2, done2);
        push_exp(3'b000, 1'b0, 1'b0);
        check_out("reset3", phase3, busy3, done3);
        Reset_n = 1'b1;
        step("idle0", 0, 0, 0, 2'b00, 0, 0);

        // 1: fields 1/1 reproduce the legacy F/G timing.
        dur2 = 16'h0101;
        step("t1_f",    1, 0, 0, 2'b01, 1, 0);
        step("t1_g",    0, 0, 0, 2'b10, 1, 0);
        step("t1_done", 0, 0, 0, 2'b00, 0, 1);
        step("t1_idle", 0, 0, 0, 2'b00, 0, 0);

        // Abort together with Start in IDLE keeps the block idle.
        step("abst_idle",  1, 1, 0, 2'b00, 0, 0);
        step("abst_idle2", 0, 0, 0, 2'b00, 0, 0);

        // 2: PHASES=3, fields 3/0/5. The zero field lasts one cycle.
        dur3 = {8'd5, 8'd0, 8'd3};
        step3("t2_p0a", 1, 3'b001, 1, 0);
        step3("t2_p0b", 0, 3'b001, 1, 0);
        step3("t2_p0c", 0, 3'b001, 1, 0);
        step3("t2_p1",  0, 3'b010, 1, 0);
        for (int i = 0; i < 5; i++) step3("t2_p2", 0, 3'b100, 1, 0);
        step3("t2_done", 0, 3'b000, 0, 1);
        step3("t2_idle", 0, 3'b000, 0, 0);

        // 3: free-run with fields 2/2, then drop Repeat in the last cycle.
        dur2 = 16'h0202;
        step("t3_a0", 1, 0, 1, 2'b01, 1, 0);
        step("t3_a1", 0, 0, 1, 2'b01, 1, 0);
        step("t3_a2", 0, 0, 1, 2'b10, 1, 0);
        step("t3_a3", 0, 0, 1, 2'b10, 1, 0);
        step("t3_b0", 0, 0, 1, 2'b01, 1, 0);
        step("t3_b1", 0, 0, 1, 2'b01, 1, 0);
        step("t3_b2", 0, 0, 1, 2'b10, 1, 0);
        step("t3_b3", 0, 0, 1, 2'b10, 1, 0);
        step("t3_done", 0, 0, 0, 2'b00, 0, 1);
        step("t3_idle", 0, 0, 0, 2'b00, 0, 0);

        // 4: abort in the second cycle of phase 1 (fields 4/4), then restart.
        dur2 = 16'h0404;
        step("t4_p0", 1, 0, 0, 2'b01, 1, 0);
        for (int i = 0; i < 3; i++) step("t4_p0", 0, 0, 0, 2'b01, 1, 0);
        step("t4_p1a",  0, 0, 0, 2'b10, 1, 0);
        step("t4_p1b",  0, 0, 0, 2'b10, 1, 0);
        step("t4_abort", 0, 1, 0, 2'b00, 0, 0);
        step("t4_re_p0", 1, 0, 0, 2'b01, 1, 0);
        for (int i = 0; i < 3; i++) step("t4_re_p0", 0, 0, 0, 2'b01, 1, 0);
        for (int i = 0; i < 4; i++) step("t4_re_p1", 0, 0, 0, 2'b10, 1, 0);
        step("t4_done", 0, 0, 0, 2'b00, 0, 1);
        step("t4_idle", 0, 0, 0, 2'b00, 0, 0);

        // 5: asynchronous reset mid-phase 0. Start and Abort are high during
        // reset; Start is still high when reset is released.
        step("t5_p0a", 1, 0, 0, 2'b01, 1, 0);
        step("t5_p0b", 0, 0, 0, 2'b01, 1, 0);
        Reset_n = 1'b0;
        start2  = 1'b1;
        abort2  = 1'b1;
        #1;
        push_exp(3'b000, 1'b0, 1'b0);
        check_out("t5_async_clr", {1'b0, phase2}, busy2, done2);
        @(posedge Clock);
        #1;
        push_exp(3'b000, 1'b0, 1'b0);
        check_out("t5_held", {1'b0, phase2}, busy2, done2);
        Reset_n = 1'b1;
        step("t5_restart", 1, 0, 0, 2'b01, 1, 0);
        step("t5_abort_p0", 0, 1, 0, 2'b00, 0, 0);

        // 6: Start held every cycle (fields 2/2). Launches come every 6
        // cycles. Duration is disturbed on edges that load nothing.
        for (int i = 0; i < 20; i++) begin
            int m;
            m = i % 6;
            dur2 = (m == 1 || m == 3) ? 16'h0707 : 16'h0202;
            case (m)
                0, 1:    step("t6_p0",   1, 0, 0, 2'b01, 1, 0);
                2, 3:    step("t6_p1",   1, 0, 0, 2'b10, 1, 0);
                4:       step("t6_done", 1, 0, 0, 2'b00, 0, 1);
                default: step("t6_idle", 1, 0, 0, 2'b00, 0, 0);
            endcase
        end
        dur2 = 16'h0202;
        step("t6_tail_p1a", 0, 0, 0, 2'b10, 1, 0);
        step("t6_tail_p1b", 0, 0, 0, 2'b10, 1, 0);
        step("t6_tail_done", 0, 0, 0, 2'b00, 0, 1);
        step("t6_tail_idle", 0, 0, 0, 2'b00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
